// File: rtl/sync_counter_pkg.sv
// Shared types and limits for the synchronous down-counter.
// Holds the FSM state encodings and the parameter lower bounds.
package sync_counter_pkg;

    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_RUN  = 1'b1;

    localparam int MIN_SIZE     = 2;
    localparam int MIN_PRESCALE = 2;

endpackage

// File: rtl/tick_prescaler.sv
// Enable divider: passes one tick per PRESCALE enabled cycles.
// Used by sync_down_counter only when SYNC_DOWN_COUNTER_PRESCALE_EN is defined.
module tick_prescaler
    import sync_counter_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

    logic [W-1:0] cnt;

    if (PRESCALE < MIN_PRESCALE) begin : g_bad_prescale
        $error("tick_prescaler: PRESCALE below minimum");
    end

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sync_down_counter.sv
// Loadable synchronous down-counter with one-shot/auto-reload and tc pulse.
// Optional enable prescaler built in with SYNC_DOWN_COUNTER_PRESCALE_EN.
module sync_down_counter
    import sync_counter_pkg::*;
#(
    parameter int SIZE     = 4,
    parameter int PRESCALE = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            load,
    input  logic [SIZE-1:0] load_val,
    input  logic            auto_reload,
    output logic [SIZE-1:0] Q,
    output logic            tc,
    output logic            busy,
    output logic            zero
);

    localparam logic [SIZE-1:0] ONE = SIZE'(1);

    state_t          state;
    logic [SIZE-1:0] reload;
    logic            tick;

    if (SIZE < MIN_SIZE) begin : g_bad_size
        $error("sync_down_counter: SIZE below minimum");
    end

`ifdef SYNC_DOWN_COUNTER_PRESCALE_EN
    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (load),
        .en   (en),
        .tick (tick)
    );
`else
    if (PRESCALE < MIN_PRESCALE) begin : g_bad_prescale
        $error("sync_down_counter: PRESCALE below minimum");
    end

    assign tick = en;
`endif

    assign busy = (state == ST_RUN);
    assign zero = (Q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            Q      <= '0;
            reload <= '0;
            tc     <= 1'b0;
            state  <= ST_IDLE;
        end else if (load) begin
            // A load always wins over a same-cycle expiry, so tc stays low
            Q      <= load_val;
            reload <= load_val;
            tc     <= 1'b0;
            state  <= (load_val != '0) ? ST_RUN : ST_IDLE;
        end else begin
            tc <= 1'b0;
            if (state == ST_RUN && tick) begin
                if (Q <= ONE) begin
                    tc <= 1'b1;
                    if (auto_reload) begin
                        Q <= reload;
                    end else begin
                        Q     <= '0;
                        state <= ST_IDLE;
                    end
                end else begin
                    Q <= Q - ONE;
                end
            end
        end
    end

endmodule

// File: doc/sync_down_counter.md
Name: sync_down_counter

Overview:
- Synchronous, loadable, binary down-counter.
- Counterpart to the team's asynchronous ripple up-counter: counts the other direction, fully synchronous, no derived clocks.
- Used as a countdown timer or event divider. Raises a one-cycle terminal-count pulse when the count expires.
- Supports one-shot mode and auto-reload mode.

Parameters:
- SIZE, 4, counter and load-value width in bits (min 2).
- PRESCALE, 4, enable divide ratio; used only when PRESCALE_EN is defined (min 2).

Ports:
- clk, input, 1, sole clock; all state updates on rising edge.
- rst, input, 1, synchronous active-high reset.
- en, input, 1, count enable; one decrement per qualified tick.
- load, input, 1, load request; captures load_val.
- load_val, input, SIZE, start/reload value.
- auto_reload, input, 1, 1 = reload on expiry; 0 = one-shot. Sampled at the expiry tick.
- Q, output, SIZE, current count.
- tc, output, 1, registered terminal-count pulse, one cycle wide.
- busy, output, 1, high while in RUN.
- zero, output, 1, combinational (Q == 0).

Behaviour:
- Reset (rst=1 at a clk edge; overrides everything):
  - Q=0, tc=0, busy=0, state=IDLE.
  - Reload register=0; prescaler count=0.
- States: IDLE, RUN. Encodings are defined in the package.
- Priority each edge: rst > load > count.
- load=1 with load_val != 0:
  - Reload register and Q take load_val; state=RUN; tc=0 that cycle; prescaler clears.
  - Applies from either state, including mid-count (restart). A pending expiry in the same cycle is cancelled, so no tc.
- load=1 with load_val == 0:
  - Q=0, reload register=0, state=IDLE, no tc.
- Qualified tick:
  - Without PRESCALE_EN: tick = en.
  - With PRESCALE_EN: see Optional Feature.
- RUN, tick, Q > 1: Q <= Q-1.
- RUN, tick, Q == 1 (expiry):
  - tc <= 1 for exactly the next cycle.
  - auto_reload=1: Q <= reload register; stay in RUN. Period = N ticks for load value N.
  - auto_reload=0: Q <= 0; state <= IDLE.
- RUN with no tick: Q holds; tc=0.
- IDLE: en ignored; Q holds; tc=0.
- No wrap-around: Q never decrements below 0, and never goes 0 -> all-ones.
- tc is registered: it rises on the same edge that Q takes its post-expiry value.
- busy = (state == RUN), registered.
- rst asserted mid-count abandons the count; no tc is generated.

Optional Feature:
- Macro: SYNC_DOWN_COUNTER_PRESCALE_EN.
- Defined:
  - Internal prescaler counts en-high cycles from 0 to PRESCALE-1.
  - tick = en && (prescaler == PRESCALE-1); the prescaler wraps to 0 on that tick.
  - The prescaler holds when en=0 and clears on rst or load.
- Undefined:
  - No prescaler logic is present; tick = en.
  - The PRESCALE parameter is unused.

Decomposition:
- Package sync_counter_pkg holds:
  - State typedef and encodings (IDLE=1'b0, RUN=1'b1).
  - Constant for minimum legal SIZE.
- Natural sub-module: tick_prescaler (params PRESCALE; ports clk, rst, clr, en, tick).
  - Instantiated only under the macro.
- Counter and FSM stay in the top module.

Test Plan:
- Reset: rst=1 for 2 cycles with load=1, load_val=4'hA -> Q=0, tc=0, busy=0; the load is ignored.
- One-shot: load 3, auto_reload=0, en=1 continuously -> Q sequence 3,2,1,0; tc high only on the cycle Q becomes 0; then busy=0; Q stays 0 for 5 more en cycles.
- Auto-reload: load 4, auto_reload=1, en=1 for 12 cycles -> Q cycles 4,3,2,1,4,3,2,1,...; tc pulses every 4th cycle (3 pulses); busy stays 1.
- Enable gaps and restart:
  - load 5; en toggles 1,0,1,0 -> Q decrements only on en=1 cycles.
  - At Q=1, assert load=1, load_val=7 together with en -> Q=7, no tc.
- Zero load: load=1, load_val=0 while Q=6 in RUN -> Q=0, state IDLE, busy=0, tc never asserts; zero=1.
- PRESCALE_EN defined, PRESCALE=4: load 2, en=1 continuously -> Q steps 2->1 after 4 cycles and 1->0 after 8 cycles; single tc on the 8th cycle.
